// File: rtl/iomem_latency_ctrl.sv
// iomem-bus responder: RAM bridge with programmable read/write latency, a
// memory-mapped 64-bit timer with compare interrupt, and a timed error response.
module iomem_latency_ctrl #(
   parameter logic [31:0] RAM_BASE_ADDR   = 32'h4000_0000,
   parameter logic [31:0] RAM_MASK_ADDR   = 32'h000F_FFFF,
   parameter logic [31:0] TIMER_BASE_ADDR = 32'h3000_0000,
   parameter int unsigned RD_LAT          = 16,
   parameter int unsigned WR_LAT          = 4,
   parameter int unsigned ERR_LAT         = 8,
   parameter int unsigned TIMER_DIV       = 1,
   parameter logic [31:0] ERR_RDATA       = 32'hDEAD_BEEF
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        iomem_valid_i,
   input  logic [3:0]  iomem_wstrb_i,
   input  logic [31:0] iomem_addr_i,
   input  logic [31:0] iomem_wdata_i,
   output logic        iomem_ready_o,
   output logic [31:0] iomem_rdata_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   output logic [3:0]  mem_wr_strb_o,
   output logic        mem_rd_en_o,
   input  logic [31:0] mem_rdata_i,
   output logic        timer_irq_o,
   output logic        bus_err_o
);

   typedef enum logic [2:0] {IDLE, RAM_RD, RAM_WR, TMR, ERR, RESP} state_t;

   localparam logic [7:0]  RD_CNT  = 8'(RD_LAT - 1);
   localparam logic [7:0]  WR_CNT  = 8'(WR_LAT - 1);
   localparam logic [7:0]  ERR_CNT = 8'(ERR_LAT - 1);
   localparam logic [15:0] DIV_TOP = 16'(TIMER_DIV - 1);

   state_t      state;
   logic [7:0]  cnt;
   logic [3:0]  wstrb_q;
   logic        rd_en_d;

   logic [15:0] presc;
   logic [63:0] mtime, mtimecmp;
   logic [63:0] mtime_nx, mtimecmp_nx;
   logic [31:0] tmr_rdata;
   logic        ram_hit, tmr_hit, tmr_wr, tick;

   assign ram_hit = (iomem_addr_i & ~RAM_MASK_ADDR) == RAM_BASE_ADDR;
   assign tmr_hit = iomem_addr_i[31:4] == TIMER_BASE_ADDR[31:4];
   assign tmr_wr  = (state == TMR) && (wstrb_q != 4'b0000);
   assign tick    = (presc == DIV_TOP);

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  strb);
      logic [31:0] res;
      res = old_w;
      for (int b = 0; b < 4; b++)
         if (strb[b]) res[8*b +: 8] = new_w[8*b +: 8];
      return res;
   endfunction

   // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
   always_comb begin
      mtime_nx    = tick ? mtime + 64'd1 : mtime;
      mtimecmp_nx = mtimecmp;
      if (tmr_wr) begin
         // A write to mtime replaces the un-incremented value for this cycle.
         case (mem_addr_o[3:2])
            2'd0: mtime_nx = {mtime[63:32], merge_bytes(mtime[31:0], mem_wdata_o, wstrb_q)};
            2'd1: mtime_nx = {merge_bytes(mtime[63:32], mem_wdata_o, wstrb_q), mtime[31:0]};
            2'd2: mtimecmp_nx = {mtimecmp[63:32], merge_bytes(mtimecmp[31:0], mem_wdata_o, wstrb_q)};
            2'd3: mtimecmp_nx = {merge_bytes(mtimecmp[63:32], mem_wdata_o, wstrb_q), mtimecmp[31:0]};
         endcase
      end
   end

   always_comb begin
      tmr_rdata = 32'h0;
      case (mem_addr_o[3:2])
         2'd0: tmr_rdata = mtime[31:0];
         2'd1: tmr_rdata = mtime[63:32];
         2'd2: tmr_rdata = mtimecmp[31:0];
         2'd3: tmr_rdata = mtimecmp[63:32];
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state         <= IDLE;
         cnt           <= 8'd0;
         wstrb_q       <= 4'b0000;
         rd_en_d       <= 1'b0;
         iomem_ready_o <= 1'b0;
         iomem_rdata_o <= 32'h0;
         mem_addr_o    <= 32'h0;
         mem_wdata_o   <= 32'h0;
         mem_wr_strb_o <= 4'b0000;
         mem_rd_en_o   <= 1'b0;
         bus_err_o     <= 1'b0;
      end else begin
         iomem_ready_o <= 1'b0;
         bus_err_o     <= 1'b0;
         mem_rd_en_o   <= 1'b0;
         mem_wr_strb_o <= 4'b0000;
         rd_en_d       <= mem_rd_en_o;
         // RAM data is valid the cycle after the read-enable pulse.
         if (rd_en_d) iomem_rdata_o <= mem_rdata_i;

         case (state)
            IDLE: begin
               if (iomem_valid_i) begin
                  mem_addr_o  <= iomem_addr_i;
                  mem_wdata_o <= iomem_wdata_i;
                  wstrb_q     <= iomem_wstrb_i;
                  if (ram_hit) begin
                     if (iomem_wstrb_i == 4'b0000) begin
                        state       <= RAM_RD;
                        mem_rd_en_o <= 1'b1;
                        cnt         <= RD_CNT;
                     end else begin
                        state         <= RAM_WR;
                        mem_wr_strb_o <= iomem_wstrb_i;
                        cnt           <= WR_CNT;
                     end
                  end else if (tmr_hit) begin
                     state <= TMR;
                  end else begin
                     state <= ERR;
                     cnt   <= ERR_CNT;
                  end
               end
            end
            RAM_RD, RAM_WR: begin
               if (cnt == 8'd0) begin
                  iomem_ready_o <= 1'b1;
                  state         <= RESP;
               end else begin
                  cnt <= cnt - 8'd1;
               end
            end
            ERR: begin
               if (cnt == 8'd0) begin
                  iomem_ready_o <= 1'b1;
                  iomem_rdata_o <= ERR_RDATA;
                  bus_err_o     <= 1'b1;
                  state         <= RESP;
               end else begin
                  cnt <= cnt - 8'd1;
               end
            end
            TMR: begin
               iomem_ready_o <= 1'b1;
               if (wstrb_q == 4'b0000) iomem_rdata_o <= tmr_rdata;
               state <= RESP;
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         presc       <= 16'd0;
         mtime       <= 64'd0;
         mtimecmp    <= 64'hFFFF_FFFF_FFFF_FFFF;
         timer_irq_o <= 1'b0;
      end else begin
         presc       <= tick ? 16'd0 : presc + 16'd1;
         mtime       <= mtime_nx;
         mtimecmp    <= mtimecmp_nx;
         timer_irq_o <= (mtime >= mtimecmp);
      end
   end

endmodule

// File: doc/iomem_latency_ctrl.md
Name: iomem_latency_ctrl

Overview:
Parametrised iomem-bus responder between the user processor's iomem port and the on-chip main memory. It replaces the fixed RAM-delay shift register and hard-wired timer decode with one FSM-driven controller. Features: separate programmable read/write memory latency, a memory-mapped 64-bit timer with compare and interrupt, and a bounded error response for unmapped addresses. One request outstanding at a time.

Parameters:
RAM_BASE_ADDR, 32'h4000_0000, RAM region base
RAM_MASK_ADDR, 32'h000F_FFFF, RAM region offset mask; hit = (addr & ~mask) == base
TIMER_BASE_ADDR, 32'h3000_0000, timer register block base (16 bytes)
RD_LAT, 16, cycles from request acceptance to ready for RAM reads; legal range 2..255
WR_LAT, 4, cycles from acceptance to ready for RAM writes; legal range 1..255
ERR_LAT, 8, cycles from acceptance to ready for unmapped accesses; legal range 1..255
TIMER_DIV, 1, mtime increments once every TIMER_DIV clocks; legal range 1..65535
ERR_RDATA, 32'hDEAD_BEEF, read data returned on unmapped access

Ports:
clk_i  in  1  system clock
rst_ni  in  1  asynchronous active-low reset
iomem_valid_i  in  1  request valid; held until ready
iomem_wstrb_i  in  4  byte write strobes; 0 = read
iomem_addr_i  in  32  byte address
iomem_wdata_i  in  32  write data
iomem_ready_o  out  1  one-cycle response pulse
iomem_rdata_o  out  32  read data; valid while ready is high
mem_addr_o  out  32  address to RAM (registered at acceptance)
mem_wdata_o  out  32  write data to RAM
mem_wr_strb_o  out  4  RAM byte write enables; one-cycle pulse
mem_rd_en_o  out  1  RAM read enable; one-cycle pulse; mem_rdata_i valid the next cycle
mem_rdata_i  in  32  RAM read data
timer_irq_o  out  1  level interrupt: mtime >= mtimecmp
bus_err_o  out  1  one-cycle pulse coincident with ready on unmapped access

Behaviour:
- Reset (async, rst_ni low): FSM=IDLE; ready, mem_wr_strb, mem_rd_en, bus_err = 0; rdata, mem_addr, mem_wdata = 0; mtime = 0; mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF; prescaler = 0; timer_irq = 0. A reset mid-transaction aborts it with no ready and no further memory strobe.
- FSM states: IDLE, RAM_RD, RAM_WR, TMR, ERR, RESP.
- IDLE: when valid=1, decode and accept the request in the same cycle. Capture addr/wdata/wstrb and load latency counter.
  - RAM hit with wstrb=0: RAM_RD; mem_rd_en pulses on the next cycle.
  - RAM hit with wstrb≠0: RAM_WR; mem_wr_strb = wstrb pulses on the next cycle.
  - Timer hit (addr[31:4] == TIMER_BASE_ADDR[31:4]): TMR.
  - Anything else: ERR.
- Counter: 8-bit down-counter loaded with LAT-1 at acceptance. Decrements each cycle in RAM_RD/RAM_WR/ERR. On reaching 0, drive ready (registered) in the next cycle. Total latency from the acceptance edge to the ready-high cycle = LAT cycles exactly.
- RAM_RD: capture mem_rdata_i into rdata one cycle after the rd_en pulse. Hold rdata until the next response.
- TMR: responds in 1 cycle (ready in the cycle after acceptance).
  - Offsets: 0x0 mtime[31:0], 0x4 mtime[63:32], 0x8 mtimecmp[31:0], 0xC mtimecmp[63:32].
  - Writes honour wstrb per byte.
  - A write to mtime overrides that cycle's increment.
- ERR: rdata = ERR_RDATA; bus_err pulses with ready; no memory strobe is issued.
- RESP: ready=1 for exactly one cycle, then IDLE. A request presented in the cycle after ready is accepted normally (back-to-back capable). valid dropping before ready is illegal and is ignored until ready.
- Timer: prescaler counts 0..TIMER_DIV-1; mtime += 1 on wrap, 64-bit wrap-around to 0. timer_irq_o is registered: mtime >= mtimecmp, unsigned 64-bit compare.
- mem_* strobes never assert outside the single pulse; no repeated writes while valid is held.

Test Plan:
- Read 0x4000_0010 with RAM word = 0x1234_5678 and RD_LAT=16 -> exactly one mem_rd_en pulse; ready 16 cycles after acceptance; rdata 0x1234_5678.
- Write 0x4000_0020 with wstrb=4'b0011 and wdata=0xAABB_CCDD, WR_LAT=4 -> single mem_wr_strb=0011 pulse; ready at 4 cycles; readback 0x????_CCDD.
- Read 0x5000_0000 -> ready after 8 cycles; rdata 0xDEAD_BEEF; bus_err pulse; no mem strobes.
- Write mtimecmp=100 and mtime=0 with TIMER_DIV=1 -> timer_irq rises when mtime reaches 100. Write mtime hi=0xFFFF_FFFF, lo=0xFFFF_FFFE -> mtime wraps to 0 after 2 cycles.
- Back-to-back: write then read to the same RAM word with valid re-asserted the cycle after ready -> both accepted; read returns the written data.
- Assert rst_ni low at cycle 5 of a RAM read -> ready never asserts; all outputs reach reset values immediately; next request after reset completes normally.
